// File: rtl/kr1533_kp11.sv
// rtl/kr1533_kp11.sv - quad 2-to-1 data selector with tri-state outputs
//
// Purpose:
//   Functional model of the KR1533KP11 (74ALS257 equivalent) used in the CPLD
//   glue logic. SA picks channel A or B, active-low CS floats Y to high-Z.
//   With REGISTERED=1 the selected data is retimed to clk through out_q.
//
// Ports:
//   clk  in   1      system clock (only affects Y when REGISTERED=1)
//   rst  in   1      synchronous active-high reset of the output register
//   A    in   WIDTH  data channel 0, selected when SA=0
//   B    in   WIDTH  data channel 1, selected when SA=1
//   SA   in   1      channel select: 0 -> A, 1 -> B
//   CS   in   1      active-low output enable: 1 puts Y at high-Z
//   Y    out  WIDTH  tri-state data output

module kr1533_kp11 #(
  parameter int WIDTH      = 4,
  parameter int REGISTERED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SA,
  input  logic             CS,
  output tri   [WIDTH-1:0] Y
);

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] y_src;

  // The conditional operator merges A and B bitwise when SA is X/Z:
  // bits where A and B agree keep that value, the rest go X.
  always_comb begin
    sel = SA ? B : A;
  end

  // The register is always present; in combinational mode it simply does not
  // reach the output driver, so clk and rst have no effect on Y there.
  always_comb begin
    out_d = sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  always_comb begin
    y_src = (REGISTERED != 0) ? out_q : sel;
  end

  // CS gates only the driver; an X on CS merges Z with data, giving X.
  assign Y = CS ? {WIDTH{1'bz}} : y_src;

endmodule

// File: tb/tb_kr1533_kp11.sv
// tb/tb_kr1533_kp11.sv - self-checking bench for kr1533_kp11
module tb_kr1533_kp11;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       sa;
  logic       cs;

  // Each mode is observed through a pulled-up and a pulled-down net: a driven
  // output reads the same on both, a floating one reads 1111 / 0000.
  tri1 [3:0] y_comb_pu;
  tri0 [3:0] y_comb_pd;
  tri1 [3:0] y_reg_pu;
  tri0 [3:0] y_reg_pd;

  int checks = 0;
  int errors = 0;

  logic [3:0] model_q;

  kr1533_kp11 #(.WIDTH(4), .REGISTERED(0)) u_comb_pu (
    .clk(clk), .rst(rst), .A(a), .B(b), .SA(sa), .CS(cs), .Y(y_comb_pu)
  );
  kr1533_kp11 #(.WIDTH(4), .REGISTERED(0)) u_comb_pd (
    .clk(clk), .rst(rst), .A(a), .B(b), .SA(sa), .CS(cs), .Y(y_comb_pd)
  );
  kr1533_kp11 #(.WIDTH(4), .REGISTERED(1)) u_reg_pu (
    .clk(clk), .rst(rst), .A(a), .B(b), .SA(sa), .CS(cs), .Y(y_reg_pu)
  );
  kr1533_kp11 #(.WIDTH(4), .REGISTERED(1)) u_reg_pd (
    .clk(clk), .rst(rst), .A(a), .B(b), .SA(sa), .CS(cs), .Y(y_reg_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the registered mode: the value captured at each rising edge.
  always @(posedge clk) begin
    if (rst) model_q <= 4'h0;
    else if (sa) model_q <= b;
    else model_q <= a;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // exp_z=1 expects a floating output, otherwise the value exp_v on Y.
  task automatic check_y(input string tag, input bit is_reg, input bit exp_z, input logic [3:0] exp_v);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = is_reg ? {y_reg_pu, y_reg_pd} : {y_comb_pu, y_comb_pd};
    exp = exp_z ? 8'hF0 : {exp_v, exp_v};
    check(tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    a   = 4'h0;
    b   = 4'h0;
    sa  = 1'b0;
    cs  = 1'b0;
    @(posedge clk); #1;
    check_y("reg_reset", 1'b1, 1'b0, 4'h0);
    rst = 1'b0;

    // Combinational directed cases.
    a = 4'hF; b = 4'h5; sa = 1'b0; cs = 1'b0;
    #2 check_y("comb_sel_a", 1'b0, 1'b0, 4'hF);
    sa = 1'b1;
    #2 check_y("comb_sel_b", 1'b0, 1'b0, 4'h5);
    cs = 1'b1;
    #1 check_y("comb_cs_hiz", 1'b0, 1'b1, 4'h0);
    cs = 1'b0;
    #1 check_y("comb_cs_on", 1'b0, 1'b0, 4'h5);

    // Exhaustive select with rst dithering while the clock runs.
    for (int i = 0; i < 512; i++) begin
      a   = i[3:0];
      b   = i[7:4];
      sa  = i[8];
      cs  = 1'b0;
      rst = 1'($urandom_range(0, 1));
      #1 check_y("comb_exh", 1'b0, 1'b0, i[8] ? i[7:4] : i[3:0]);
    end
    rst = 1'b0;

    // Registered directed cases.
    @(posedge clk); #1;
    rst = 1'b1; cs = 1'b0;
    @(posedge clk); #1;
    check_y("reg_rst_zero", 1'b1, 1'b0, 4'h0);
    rst = 1'b0; a = 4'hA; sa = 1'b0;
    #1 check_y("reg_before_edge", 1'b1, 1'b0, 4'h0);
    @(posedge clk); #1;
    check_y("reg_after_edge", 1'b1, 1'b0, 4'hA);

    cs = 1'b1; b = 4'h3; sa = 1'b1;
    @(posedge clk); #1;
    check_y("reg_cs_hiz", 1'b1, 1'b1, 4'h0);
    cs = 1'b0;
    #1 check_y("reg_cs_on", 1'b1, 1'b0, 4'h3);
    rst = 1'b1; b = 4'h7;
    @(posedge clk); #1;
    check_y("reg_rst_prio", 1'b1, 1'b0, 4'h0);
    rst = 1'b0;

    // Randomized traffic against both modes.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      sa  = 1'($urandom_range(0, 1));
      cs  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 7) == 0);
      #1;
      check_y("rand_comb", 1'b0, cs, sa ? b : a);
      check_y("rand_reg", 1'b1, cs, model_q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
